fwd_scoreboard: RTL and testbench

//  Parametrised forwarding and hazard unit for the ID stage.
//  - Tracks every in-flight register write across NUM_STAGES post-ID stages (EXE, MEM, MEM2, WB, ...).
//  - For each of NUM_SRC ID source operands, selects the youngest matching producer.
//  - Raises a stall while that producer's result is not yet available (load-use, multi-cycle mul/div).
//  - Replaces the fixed 4-stage, 2-source combinational forward select.

---
 rtl/fwd_scoreboard.sv | 123 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// ID-stage forwarding and hazard unit. It tracks in-flight register writes across the post-ID
// stages, selects the youngest producer for each source operand and stalls until that result is ready.
module fwd_scoreboard #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LAT_W      = 3,
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     id_valid,
    input  logic                     id_wr_en,
    input  logic [4:0]               id_dst,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic [NUM_SRC*5-1:0]     id_src,
    input  logic                     pipe_adv,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     hazard_stall,
    output logic                     id_fire
);

    logic             vld_q [NUM_STAGES];
    logic             vld_d [NUM_STAGES];
    logic [4:0]       dst_q [NUM_STAGES];
    logic [4:0]       dst_d [NUM_STAGES];
    logic [LAT_W-1:0] cnt_q [NUM_STAGES];
    logic [LAT_W-1:0] cnt_d [NUM_STAGES];
    logic [LAT_W-1:0] cnt_dec [NUM_STAGES];

    // Low for the first cycle after reset release; keeps all outputs quiet that cycle.
    logic live_q;
    logic out_en;

    logic [SEL_W-1:0] sel_raw [NUM_SRC];
    logic [NUM_SRC-1:0] need_wait;
    logic stall_raw;

    assign out_en = resetn & live_q;

    // Youngest match wins: scan from oldest to youngest so the last hit is the lowest stage.
    always_comb begin
        logic [4:0] src;
        src = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src          = id_src[i*5 +: 5];
            sel_raw[i]   = '0;
            need_wait[i] = 1'b0;
            for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
                if (vld_q[s] && (dst_q[s] == src) && (src != 5'd0)) begin
                    sel_raw[i]   = SEL_W'(s + 1);
                    need_wait[i] = (cnt_q[s] != '0);
                end
            end
        end
    end

    assign stall_raw = id_valid & (|need_wait);

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            fwd_sel[i*SEL_W +: SEL_W] = out_en ? sel_raw[i] : '0;
        end
    end

    assign hazard_stall = out_en & stall_raw;
    assign id_fire      = out_en & id_valid & pipe_adv & ~stall_raw & ~flush;

    // Countdown runs every cycle, independent of pipe_adv.
    always_comb begin
        for (int s = 0; s < int'(NUM_STAGES); s++) begin
            cnt_dec[s] = (cnt_q[s] != '0) ? cnt_q[s] - LAT_W'(1) : '0;
        end
    end

    always_comb begin
        for (int s = 0; s < int'(NUM_STAGES); s++) begin
            vld_d[s] = vld_q[s];
            dst_d[s] = dst_q[s];
            cnt_d[s] = cnt_dec[s];
        end
        if (flush) begin
            for (int s = 0; s < int'(NUM_STAGES); s++) begin
                vld_d[s] = 1'b0;
            end
        end else if (pipe_adv) begin
            for (int s = int'(NUM_STAGES) - 1; s >= 1; s--) begin
                vld_d[s] = vld_q[s-1];
                dst_d[s] = dst_q[s-1];
                cnt_d[s] = cnt_dec[s-1];
            end
            vld_d[0] = id_fire & id_wr_en & (id_dst != 5'd0);
            dst_d[0] = id_dst;
            cnt_d[0] = id_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            live_q <= 1'b0;
            for (int s = 0; s < int'(NUM_STAGES); s++) begin
                vld_q[s] <= 1'b0;
                dst_q[s] <= '0;
                cnt_q[s] <= '0;
            end
        end else begin
            live_q <= 1'b1;
            for (int s = 0; s < int'(NUM_STAGES); s++) begin
                vld_q[s] <= vld_d[s];
                dst_q[s] <= dst_d[s];
                cnt_q[s] <= cnt_d[s];
            end
        end
    end

    // An entry leaving the last stage must already be ready; otherwise id_lat broke its contract.
    logic retire_err;
    assign retire_err = vld_q[NUM_STAGES-1] & (cnt_q[NUM_STAGES-1] != '0) & pipe_adv & ~flush;

    a_retire_ready: assert property (@(posedge clk) disable iff (!resetn) !retire_err);

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: a 4-stage/2-source and a 6-stage/3-source instance share one stimulus
// stream and are compared against a queue-based model of in-flight writes with absolute ready times.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid;
    logic        id_wr_en;
    logic [4:0]  id_dst;
    logic [2:0]  id_lat;
    logic [14:0] src_bus;
    logic        pipe_adv;
    logic        flush;

    logic [5:0]  d4_sel;
    logic        d4_stall;
    logic        d4_fire;
    logic [8:0]  d6_sel;
    logic        d6_stall;
    logic        d6_fire;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fwd_scoreboard u_dut4 (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_wr_en     (id_wr_en),
        .id_dst       (id_dst),
        .id_lat       (id_lat),
        .id_src       (src_bus[9:0]),
        .pipe_adv     (pipe_adv),
        .flush        (flush),
        .fwd_sel      (d4_sel),
        .hazard_stall (d4_stall),
        .id_fire      (d4_fire)
    );

    fwd_scoreboard #(
        .NUM_STAGES (6),
        .NUM_SRC    (3)
    ) u_dut6 (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_wr_en     (id_wr_en),
        .id_dst       (id_dst),
        .id_lat       (id_lat),
        .id_src       (src_bus),
        .pipe_adv     (pipe_adv),
        .flush        (flush),
        .fwd_sel      (d6_sel),
        .hazard_stall (d6_stall),
        .id_fire      (d6_fire)
    );

    // Model: one record per in-flight write; stg 0 = EXE; ready from cycle rdy onwards.
    typedef struct {
        int     dst;
        longint rdy;
        int     stg;
    } ent_t;

    ent_t   mq [2][$];
    bit     m_init [2];
    bit     m_fire [2];
    longint now = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int m_youngest(input int inst, input int src);
        int best = -1;
        if (src == 0) return -1;
        foreach (mq[inst][k]) begin
            if (mq[inst][k].dst == src && (best < 0 || mq[inst][k].stg < mq[inst][best].stg))
                best = k;
        end
        return best;
    endfunction

    task automatic mcheck(input int inst, input logic [8:0] sel_bus, input logic stall,
                          input logic fire);
        int  nsrc = (inst == 0) ? 2 : 3;
        bit  en   = resetn && !m_init[inst];
        bit  exp_stall = 1'b0;
        bit  exp_fire;
        for (int i = 0; i < nsrc; i++) begin
            int k   = m_youngest(inst, int'(src_bus[i*5 +: 5]));
            int sel = (en && k >= 0) ? mq[inst][k].stg + 1 : 0;
            check($sformatf("d%0d_sel%0d", inst, i), 32'(sel_bus[i*3 +: 3]), 32'(sel));
            if (sel != 0 && mq[inst][k].rdy > now && id_valid) exp_stall = 1'b1;
        end
        exp_fire = en && id_valid && pipe_adv && !exp_stall && !flush;
        check($sformatf("d%0d_stall", inst), 32'(stall), 32'(exp_stall));
        check($sformatf("d%0d_fire", inst), 32'(fire), 32'(exp_fire));
        m_fire[inst] = exp_fire;
    endtask

    task automatic drive(input bit r, input bit v, input bit w, input int dst, input int lat,
                         input int s0, input int s1, input int s2, input bit a, input bit f);
        resetn   = r;
        id_valid = v;
        id_wr_en = w;
        id_dst   = 5'(dst);
        id_lat   = 3'(lat);
        src_bus  = {5'(s2), 5'(s1), 5'(s0)};
        pipe_adv = a;
        flush    = f;
        #1;
        mcheck(0, {3'b000, d4_sel}, d4_stall, d4_fire);
        mcheck(1, d6_sel, d6_stall, d6_fire);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int inst = 0; inst < 2; inst++) begin
            int ns = (inst == 0) ? 4 : 6;
            if (!resetn) begin
                mq[inst].delete();
                m_init[inst] = 1'b1;
            end else begin
                m_init[inst] = 1'b0;
                if (flush) begin
                    mq[inst].delete();
                end else if (pipe_adv) begin
                    foreach (mq[inst][k]) mq[inst][k].stg++;
                    while (mq[inst].size() > 0 && mq[inst][$].stg >= ns) void'(mq[inst].pop_back());
                    if (m_fire[inst] && id_wr_en && id_dst != 5'd0)
                        mq[inst].push_front('{dst: int'(id_dst), rdy: now + 1 + longint'(id_lat), stg: 0});
                end
            end
        end
        now++;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // Reset with a random input stream
        for (int c = 0; c < 2; c++) begin
            drive(0, 1'($urandom), 1'($urandom), $urandom % 8, $urandom % 4,
                  $urandom % 8, $urandom % 8, $urandom % 8, 1'($urandom), 1'b0);
            check("rst_sel", 32'(d4_sel), 0);
            check("rst_stall", 32'(d4_stall), 0);
            tick();
        end
        drive(1, 1, 1, 4, 0, 0, 0, 0, 1, 0);
        check("rel_sel", 32'(d4_sel), 0);
        check("rel_fire", 32'(d4_fire), 0);
        tick();

        // Back-to-back ALU forwarding
        drive(1, 1, 1, 3, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 3, 0, 0, 1, 0);
        check("alu_sel_exe", 32'(d4_sel[2:0]), 1);
        check("alu_stall", 32'(d4_stall), 0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 3, 0, 0, 1, 0);
        check("alu_sel_s2", 32'(d4_sel[2:0]), 3);
        tick();
        drive(1, 0, 0, 0, 0, 3, 0, 0, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 3, 0, 0, 1, 0);
        check("alu_sel_gone", 32'(d4_sel[2:0]), 0);
        tick();

        // Load-use: one stall cycle, then forward from MEM
        drive(1, 1, 1, 5, 1, 0, 0, 0, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 5, 0, 1, 0);
        check("ld_stall", 32'(d4_stall), 1);
        tick();
        drive(1, 1, 0, 0, 0, 0, 5, 0, 1, 0);
        check("ld_stall_clr", 32'(d4_stall), 0);
        check("ld_sel_mem", 32'(d4_sel[5:3]), 2);
        tick();

        // Divide lat=3: three stall cycles, with a held pipe in the middle
        drive(1, 1, 1, 6, 3, 0, 0, 0, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 6, 0, 0, 1, 0);
        check("div_stall1", 32'(d4_stall), 1);
        tick();
        drive(1, 1, 0, 0, 0, 6, 0, 0, 0, 0);
        check("div_stall2", 32'(d4_stall), 1);
        tick();
        drive(1, 1, 0, 0, 0, 6, 0, 0, 1, 0);
        check("div_stall3", 32'(d4_stall), 1);
        tick();
        drive(1, 1, 0, 0, 0, 6, 0, 0, 1, 0);
        check("div_ready", 32'(d4_stall), 0);
        check("div_sel", 32'(d4_sel[2:0]), 3);
        tick();

        // Youngest unready producer wins over an older ready one
        drive(1, 1, 1, 7, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 1, 1, 7, 2, 0, 0, 0, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 7, 7, 0, 1, 0);
        check("yw_sel0", 32'(d4_sel[2:0]), 1);
        check("yw_sel1", 32'(d4_sel[5:3]), 1);
        check("yw_stall", 32'(d4_stall), 1);
        tick();

        // Flush beats advance and insertion
        drive(1, 1, 1, 9, 0, 0, 0, 0, 1, 1);
        check("fl_fire", 32'(d4_fire), 0);
        tick();
        drive(1, 1, 0, 0, 0, 7, 9, 7, 1, 0);
        check("fl_sel4", 32'(d4_sel), 0);
        check("fl_sel6", 32'(d6_sel), 0);
        check("fl_stall", 32'(d4_stall), 0);
        tick();

        // $0 is never tracked; own dst is not self-matched
        drive(1, 1, 1, 0, 3, 0, 0, 0, 1, 0); tick();
        drive(1, 1, 1, 11, 0, 0, 11, 0, 1, 0);
        check("r0_sel", 32'(d4_sel[2:0]), 0);
        check("r0_stall", 32'(d4_stall), 0);
        check("self_sel", 32'(d4_sel[5:3]), 0);
        tick();
        drive(1, 1, 0, 0, 0, 11, 0, 0, 1, 0);
        check("self_next", 32'(d4_sel[2:0]), 1);
        tick();

        // Six-stage instance: third source sees the oldest stage
        drive(1, 1, 1, 12, 0, 0, 0, 0, 1, 0); tick();
        for (int c = 0; c < 5; c++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 12, 1, 0);
        check("p6_sel2", 32'(d6_sel[8:6]), 6);
        tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 64) != 0, ($urandom % 4) != 0, ($urandom % 10) < 7, $urandom % 8,
                  $urandom % 4, $urandom % 8, $urandom % 8, $urandom % 8,
                  ($urandom % 5) != 0, ($urandom % 20) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
